// File: rtl/gpio_pkg.sv
// Shared constants for the two-bank GPIO block: register-select codes and bank width.
package gpio_pkg;

  localparam int unsigned BankWidth = 8;

  localparam logic [2:0] REG_WR_A  = 3'd0;
  localparam logic [2:0] REG_DIR_A = 3'd1;
  localparam logic [2:0] REG_RD_A  = 3'd2;
  localparam logic [2:0] REG_WR_B  = 3'd3;
  localparam logic [2:0] REG_DIR_B = 3'd4;
  localparam logic [2:0] REG_RD_B  = 3'd5;

endpackage

// File: rtl/gpio_bank.sv
// One 8-pin GPIO bank: output-data and direction registers, per-bit tristate
// drivers and a live read-back of the pin levels.
module gpio_bank
  import gpio_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_we_wr,
  input  logic                 i_we_dir,
  input  logic [BankWidth-1:0] i_di,
  output logic [BankWidth-1:0] o_wr,
  output logic [BankWidth-1:0] o_dir,
  output logic [BankWidth-1:0] o_rd,
  inout  wire  [BankWidth-1:0] io_pins
);

  logic [BankWidth-1:0] r_wr;
  logic [BankWidth-1:0] r_dir;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr  <= '0;
      r_dir <= '0;
    end else begin
      if (i_we_wr) begin
        r_wr <= i_di;
      end
      if (i_we_dir) begin
        r_dir <= i_di;
      end
    end
  end

  // Each pin is driven only while its own direction bit is set.
  for (genvar g_bit = 0; g_bit < BankWidth; g_bit++) begin : g_pin
    assign io_pins[g_bit] = r_dir[g_bit] ? r_wr[g_bit] : 1'bz;
  end

  assign o_wr  = r_wr;
  assign o_dir = r_dir;
  assign o_rd  = io_pins;

endmodule

// File: rtl/gpio.sv
// Two-bank 16-pin GPIO peripheral: register-select decode, read mux and
// byte-lane replication around two gpio_bank instances.
module gpio
  import gpio_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [2:0]  i_reg_sel,
  input  logic        i_we,
  input  logic [31:0] i_di,
  output logic [31:0] o_do,
  inout  wire  [15:0] io_ports
);

  logic                 w_we_wr_a;
  logic                 w_we_dir_a;
  logic                 w_we_wr_b;
  logic                 w_we_dir_b;
  logic [BankWidth-1:0] w_wr_a;
  logic [BankWidth-1:0] w_dir_a;
  logic [BankWidth-1:0] w_rd_a;
  logic [BankWidth-1:0] w_wr_b;
  logic [BankWidth-1:0] w_dir_b;
  logic [BankWidth-1:0] w_rd_b;
  logic [BankWidth-1:0] w_sel_byte;
  logic                 w_unused_di;

  // Only the low byte lane carries write data.
  assign w_unused_di = ^i_di[31:BankWidth];

  assign w_we_wr_a  = i_we && (i_reg_sel == REG_WR_A);
  assign w_we_dir_a = i_we && (i_reg_sel == REG_DIR_A);
  assign w_we_wr_b  = i_we && (i_reg_sel == REG_WR_B);
  assign w_we_dir_b = i_we && (i_reg_sel == REG_DIR_B);

  gpio_bank u_bank_a (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_we_wr  (w_we_wr_a),
    .i_we_dir (w_we_dir_a),
    .i_di     (i_di[BankWidth-1:0]),
    .o_wr     (w_wr_a),
    .o_dir    (w_dir_a),
    .o_rd     (w_rd_a),
    .io_pins  (io_ports[7:0])
  );

  gpio_bank u_bank_b (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_we_wr  (w_we_wr_b),
    .i_we_dir (w_we_dir_b),
    .i_di     (i_di[BankWidth-1:0]),
    .o_wr     (w_wr_b),
    .o_dir    (w_dir_b),
    .o_rd     (w_rd_b),
    .io_pins  (io_ports[15:8])
  );

  // Codes 5..7 all alias the bank B pin read-back.
  always_comb begin
    w_sel_byte = w_rd_b;
    case (i_reg_sel)
      REG_WR_A:  w_sel_byte = w_wr_a;
      REG_DIR_A: w_sel_byte = w_dir_a;
      REG_RD_A:  w_sel_byte = w_rd_a;
      REG_WR_B:  w_sel_byte = w_wr_b;
      REG_DIR_B: w_sel_byte = w_dir_b;
      default:   w_sel_byte = w_rd_b;
    endcase
  end

  assign o_do = {4{w_sel_byte}};

endmodule

// File: tb/tb_gpio.sv
// Directed self-checking bench for gpio: reset, input read-back, output drive,
// mixed direction, ignored writes and reset-over-write priority.
module tb_gpio;

  logic        clk;
  logic        reset;
  logic [2:0]  reg_sel;
  logic        we;
  logic [31:0] di;
  logic [31:0] dout;
  wire  [15:0] ports;
  logic [15:0] ext_drv;
  logic [15:0] ext_en;

  int n_checks;
  int n_errors;

  gpio dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_reg_sel (reg_sel),
    .i_we      (we),
    .i_di      (di),
    .o_do      (dout),
    .io_ports  (ports)
  );

  for (genvar g = 0; g < 16; g++) begin : g_ext
    assign ports[g] = ext_en[g] ? ext_drv[g] : 1'bz;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] data);
    reg_sel = sel;
    di      = data;
    we      = 1'b1;
    tick();
    we      = 1'b0;
    di      = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] sel, input logic [31:0] exp);
    reg_sel = sel;
    #1;
    check(tag, dout, exp);
  endtask

  // A floating pin follows whatever the bench drives onto it, both 0 and 1.
  task automatic float_chk(input string tag, input logic [15:0] mask);
    ext_en  = mask;
    ext_drv = 16'h0000;
    #1;
    check({tag, "_lo"}, {16'h0, ports & mask}, 32'h0);
    ext_drv = 16'hFFFF;
    #1;
    check({tag, "_hi"}, {16'h0, ports & mask}, {16'h0, mask});
    ext_en  = 16'h0000;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    we       = 1'b0;
    reg_sel  = 3'd0;
    di       = '0;
    ext_drv  = '0;
    ext_en   = '0;
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    rd("rst_wr_a", 3'd0, 32'h0);
    rd("rst_dir_a", 3'd1, 32'h0);
    rd("rst_wr_b", 3'd3, 32'h0);
    rd("rst_dir_b", 3'd4, 32'h0);
    float_chk("rst_float", 16'hFFFF);

    // Input read-back
    ext_en  = 16'hFFFF;
    ext_drv = 16'hFF00;
    rd("in_rd_a", 3'd2, 32'h0000_0000);
    rd("in_rd_b5", 3'd5, 32'hFFFF_FFFF);
    rd("in_rd_b6", 3'd6, 32'hFFFF_FFFF);
    rd("in_rd_b7", 3'd7, 32'hFFFF_FFFF);
    ext_drv = 16'h5AC3;
    rd("in_rd_a2", 3'd2, 32'hC3C3_C3C3);
    rd("in_rd_b2", 3'd5, 32'h5A5A_5A5A);
    ext_en  = 16'h0000;

    // Output bank A
    wr(3'd0, 32'hFFFF_FFFF);
    rd("outa_wr", 3'd0, 32'hFFFF_FFFF);
    float_chk("outa_wr_float", 16'h00FF);
    reg_sel = 3'd1;
    di      = 32'h0000_00FF;
    we      = 1'b1;
    #1;
    check("outa_dir_old", dout, 32'h0);
    tick();
    we = 1'b0;
    check("outa_dir_new", dout, 32'hFFFF_FFFF);
    check("outa_pins", {24'h0, ports[7:0]}, 32'hFF);
    rd("outa_rd", 3'd2, 32'hFFFF_FFFF);
    float_chk("outa_b_float", 16'hFF00);

    // Output bank B
    wr(3'd3, 32'hFFFF_FFFF);
    float_chk("outb_wr_float", 16'hFF00);
    wr(3'd4, 32'hFFFF_FFFF);
    rd("outb_wr", 3'd3, 32'hFFFF_FFFF);
    rd("outb_dir", 3'd4, 32'hFFFF_FFFF);
    check("outb_pins", {16'h0, ports}, 32'hFFFF);
    rd("outb_rd", 3'd5, 32'hFFFF_FFFF);

    // Mixed direction on bank A
    wr(3'd0, 32'h0000_00A5);
    wr(3'd1, 32'h0000_000F);
    check("mix_low", {28'h0, ports[3:0]}, 32'h5);
    float_chk("mix_float", 16'h00F0);
    ext_en  = 16'h00F0;
    ext_drv = 16'h0030;
    rd("mix_rd", 3'd2, 32'h3535_3535);
    ext_en  = 16'h0000;

    // Ignored writes and upper data bits
    wr(3'd2, 32'h0000_00FF);
    wr(3'd7, 32'h0000_00FF);
    rd("ign_wr_a", 3'd0, 32'hA5A5_A5A5);
    rd("ign_dir_a", 3'd1, 32'h0F0F_0F0F);
    rd("ign_wr_b", 3'd3, 32'hFFFF_FFFF);
    rd("ign_dir_b", 3'd4, 32'hFFFF_FFFF);
    wr(3'd3, 32'hFFFF_FF3C);
    rd("hi_di_ign", 3'd3, 32'h3C3C_3C3C);
    check("hi_di_pins", {24'h0, ports[15:8]}, 32'h3C);

    // Reset wins over a simultaneous write
    reset = 1'b1;
    wr(3'd0, 32'h0000_00FF);
    reset = 1'b0;
    rd("prio_wr_a", 3'd0, 32'h0);
    rd("prio_dir_a", 3'd1, 32'h0);
    rd("prio_wr_b", 3'd3, 32'h0);
    rd("prio_dir_b", 3'd4, 32'h0);
    float_chk("prio_float", 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gpio.md
# gpio

Two-bank, 16-pin general-purpose I/O peripheral on the processor's memory-mapped peripheral bus. Each 8-bit bank (A = pins 7:0, B = pins 15:8) has an output-data register and a direction register, and a read-only view of the live pin levels. Register access is byte-wide on a 32-bit data bus, selected by a 3-bit register select.

## Interface
Parameters: none (bank width 8 and bank count 2 are fixed).

- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- regSel  input  3  register select (see map)
- we  input  1  write enable; write to the selected register on the next rising clk edge
- di  input  32  write data; only di[7:0] is used
- do  output  32  read data, combinational from regSel
- ports  inout  16  GPIO pins; [7:0] bank A, [15:8] bank B

## Operation
Register map (regSel):
- 000 GPIOWR_A: R/W, 8-bit output data for pins 7:0
- 001 GPIODIR_A: R/W, 8-bit direction for pins 7:0; 1 = output, 0 = input (Hi-Z)
- 010 GPIORD_A: read-only, live level of ports[7:0]; writes ignored
- 011 GPIOWR_B: R/W, output data for pins 15:8
- 100 GPIODIR_B: R/W, direction for pins 15:8
- 101, 110, 111 GPIORD_B: read-only, live level of ports[15:8]; writes ignored

Rules:
- Pin drive: for each bit i of a bank, the pin is driven with WR[i] when DIR[i]=1, otherwise it is 1'bz. This is independent per bit.
- Read: the selected 8-bit value is replicated into all four byte lanes: do = {4{sel_byte}}. The CPU picks its lane by address.
- GPIORD reflects the actual pin level, including pins this block drives as outputs. There is no input synchronizer or filter.
- Write: when we=1 at a rising clk edge, di[7:0] is loaded into the selected WR or DIR register. di[31:8] is ignored.
- Reset: when reset=1 at a rising clk edge, all four registers are set to 8'h00. All pins then float (Hi-Z). Reset has priority over we.

## Timing
- Write latency: 1 cycle. The register updates at the capturing edge.
- Pin drive: changes combinationally from the register outputs, so a pin changes immediately after the edge that updates WR or DIR.
- Read path: fully combinational from regSel and from the pins. There are no wait states and no read side effects.
- Write and read of the same register in the same cycle: do shows the old value until the edge, the new value after it.
- Before the first reset the register contents are undefined. The bench must apply reset before checking.

## Structure
- Shared package: 3-bit register-select constants (REG_WR_A=0, REG_DIR_A=1, REG_RD_A=2, REG_WR_B=3, REG_DIR_B=4, REG_RD_B=5) and bank width (8).
- One sub-module, gpio_bank, instantiated twice. Each instance contains:
  - the WR and DIR registers
  - the write-enable decode inputs
  - per-bit tristate drivers
  - the pin read-back output
- Top level contains the regSel decode, the read mux and the byte replication.

## Test plan
- Reset: assert reset for 1 edge, release. Reading regSel 000, 001, 011 and 100 each returns do=32'h0. All ports read z.
- Input read A: external drive ports=16'hFF00, regSel=010 -> do[23:16]=8'h00 (all lanes 8'h00). Then regSel=101 -> do[15:8]=8'hFF (do=32'hFFFFFFFF).
- Output A: release external drive. di=32'hFFFFFFFF, we=1, regSel=000 for 1 edge -> GPIOWR_A=8'hFF, ports[7:0] still z. Then regSel=001 for 1 edge -> GPIODIR_A=8'hFF, ports[7:0]=8'hFF.
- Output B: same sequence with regSel 011 and 100 -> GPIOWR_B=GPIODIR_B=8'hFF, ports[15:8]=8'hFF, ports[7:0] unaffected.
- Mixed direction: WR_A=8'hA5, DIR_A=8'h0F -> ports[3:0]=4'h5, ports[7:4]=z. Reading regSel 010 with the upper nibble externally driven to 4'h3 -> do=32'h35353535.
- Ignored writes and priority:
  - we=1 on regSel 010 or 111 with di=8'hFF -> no register changes.
  - we=1 together with reset=1 -> all registers are 0 after the edge.
